// File: rtl/ft600_bus_arbiter.sv
// ft600_bus_arbiter
//
// Direction arbiter and bus sequencer for the FT600 245-mode FIFO bus, in the
// FT600 clock domain. Each burst either reads FT600 -> local RX FIFO or writes
// local TX FIFO -> FT600. Bursts are capped at BURST_LEN words. When both
// sides request, the side not served last wins (round robin).
//
// Handshake: a word moves in a cycle only when the cycle's strobe
// (rx_wr / tx_rd) is high. rx_wr means the word on ft_data is valid and the
// RX FIFO has room. tx_rd means the FT600 has space and the TX FIFO head is
// taken. No other ready/valid pairing exists.
//
// Ports
//   clk, rst    : FT600 clock, asynchronous active-high reset
//   ft_rxf      : RXF_N, low = FT600 has read data
//   ft_txe      : TXE_N, low = FT600 has write space
//   rx_afull    : RX FIFO has fewer than 2 free words
//   tx_empty    : TX FIFO empty
//   ft_oe/ft_rd : OE_N / RD_N, registered
//   ft_wr       : WR_N, combinational
//   ft_data_oe  : glue drives ft_data/ft_be onto the bus
//   rx_wr       : push the current bus word into the RX FIFO
//   tx_rd       : TX FIFO head is transferred; pop it
//   busy        : sequencer not idle
//   dir         : last granted direction (0 = RX, 1 = TX)

module ft600_bus_arbiter #(
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic ft_rxf,
    input  logic ft_txe,
    input  logic rx_afull,
    input  logic tx_empty,
    output logic ft_oe,
    output logic ft_rd,
    output logic ft_wr,
    output logic ft_data_oe,
    output logic rx_wr,
    output logic tx_rd,
    output logic busy,
    output logic dir
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RX_OE = 3'd1,
        S_RX_RD = 3'd2,
        S_TX_WR = 3'd3,
        S_TURN  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_dir_q, last_dir_d;
    logic             ft_oe_q, ft_rd_q;
    logic             rx_req, tx_req;

    assign rx_req = !ft_rxf && !rx_afull;
    assign tx_req = !ft_txe && !tx_empty;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_dir_d = last_dir_q;
        ft_wr      = 1'b1;
        ft_data_oe = 1'b0;
        rx_wr      = 1'b0;
        tx_rd      = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // On a tie, last_dir = 1 (TX served last) hands the bus to RX.
                if (rx_req && (!tx_req || last_dir_q)) begin
                    state_d = S_RX_OE;
                end else if (tx_req) begin
                    state_d = S_TX_WR;
                end
            end

            S_RX_OE: begin
                // One turnaround cycle so the FT600 takes over the bus.
                if (!ft_rxf) begin
                    state_d = S_RX_RD;
                end else begin
                    state_d    = S_TURN;
                    cnt_d      = '0;
                    last_dir_d = 1'b0;
                end
            end

            S_RX_RD: begin
                rx_wr = !ft_rxf;
                if (rx_wr) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Leaving on the last counted word keeps the burst at exactly
                // BURST_LEN transfers.
                if (ft_rxf || rx_afull || (rx_wr && cnt_q == CNT_LAST)) begin
                    state_d    = S_TURN;
                    cnt_d      = '0;
                    last_dir_d = 1'b0;
                end
            end

            S_TX_WR: begin
                ft_data_oe = 1'b1;
                ft_wr      = tx_empty;
                tx_rd      = !tx_empty && !ft_txe;
                if (tx_rd) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (ft_txe || tx_empty || (tx_rd && cnt_q == CNT_LAST)) begin
                    state_d    = S_TURN;
                    cnt_d      = '0;
                    last_dir_d = 1'b1;
                end
            end

            S_TURN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_dir_q <= 1'b1;
            ft_oe_q    <= 1'b1;
            ft_rd_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_dir_q <= last_dir_d;
            // OE/RD are registered from the next state so they change with it.
            ft_oe_q    <= !(state_d == S_RX_OE || state_d == S_RX_RD);
            ft_rd_q    <= !(state_d == S_RX_RD);
        end
    end

    assign ft_oe = ft_oe_q;
    assign ft_rd = ft_rd_q;
    assign busy  = (state_q != S_IDLE);
    assign dir   = last_dir_q;

endmodule
